// File: rtl/div_sequencer_pkg.sv
// Shared constants and FSM state encoding for the iterative divider.
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift, trial subtract, insert quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] work,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] work_next
);

    // Upper half after the shift needs W+1 bits: the bit shifted out still counts.
    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        partial = work[2*WIDTH-1:WIDTH-1];
        diff    = partial - {1'b0, divisor};
        fits    = ~diff[WIDTH];
        work_next[WIDTH-1:0] = {work[WIDTH-2:0], fits};
        if (fits)
            work_next[2*WIDTH-1:WIDTH] = diff[WIDTH-1:0];
        else
            work_next[2*WIDTH-1:WIDTH] = partial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// DIV/DIVU controller: operand latch, 32-step restoring sequence, sign fix-up, HI/LO result.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int ITER_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic               cancel,
    input  logic [WIDTH-1:0]   operand_1,
    input  logic [WIDTH-1:0]   operand_2,
    output logic               stall_request,
    output logic               result_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [ITER_W-1:0] LAST = ITER_W'(WIDTH - 1);

    div_state_e         state;
    logic [ITER_W-1:0]  counter;
    logic [WIDTH-1:0]   divisor;
    logic [2*WIDTH-1:0] work;
    logic [2*WIDTH-1:0] work_next;
    logic               sign_q;
    logic               sign_r;

    logic               neg_1;
    logic               neg_2;
    logic [WIDTH-1:0]   abs_1;
    logic [WIDTH-1:0]   abs_2;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign neg_1 = signed_div & operand_1[WIDTH-1];
    assign neg_2 = signed_div & operand_2[WIDTH-1];
    assign abs_1 = neg_1 ? (~operand_1 + 1'b1) : operand_1;
    assign abs_2 = neg_2 ? (~operand_2 + 1'b1) : operand_2;

    div_step #(.WIDTH(WIDTH)) u_step (
        .work      (work),
        .divisor   (divisor),
        .work_next (work_next)
    );

    assign q_fix = sign_q ? (~work_next[WIDTH-1:0] + 1'b1) : work_next[WIDTH-1:0];
    assign r_fix = sign_r ? (~work_next[2*WIDTH-1:WIDTH] + 1'b1) : work_next[2*WIDTH-1:WIDTH];

    // Low in END so EX advances on the cycle the result is presented.
    assign stall_request = start & ~cancel & (state != DIV_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= DIV_IDLE;
            counter      <= '0;
            divisor      <= '0;
            work         <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            result       <= '0;
            result_ready <= 1'b0;
        end else if (cancel) begin
            state        <= DIV_IDLE;
            result       <= '0;
            result_ready <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    result_ready <= 1'b0;
                    if (start) begin
                        if (operand_2 == '0) begin
                            state <= DIV_ZERO;
                        end else begin
                            state   <= DIV_ON;
                            divisor <= abs_2;
                            work    <= {{WIDTH{1'b0}}, abs_1};
                            sign_q  <= neg_1 ^ neg_2;
                            sign_r  <= neg_1;
                            counter <= '0;
                        end
                    end
                end
                DIV_ON: begin
                    if (!start) begin
                        state        <= DIV_IDLE;
                        result       <= '0;
                        result_ready <= 1'b0;
                    end else begin
                        work    <= work_next;
                        counter <= counter + ITER_W'(1);
                        if (counter == LAST) begin
                            state        <= DIV_END;
                            result       <= {r_fix, q_fix};
                            result_ready <= 1'b1;
                        end
                    end
                end
                DIV_ZERO: begin
                    result <= '0;
                    if (!start) begin
                        state        <= DIV_IDLE;
                        result_ready <= 1'b0;
                    end else begin
                        state        <= DIV_END;
                        result_ready <= 1'b1;
                    end
                end
                DIV_END: begin
                    if (!start) begin
                        state        <= DIV_IDLE;
                        result_ready <= 1'b0;
                    end
                end
                default: begin
                    state        <= DIV_IDLE;
                    result_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized and directed bench for div_sequencer against an arithmetic reference model.
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        cancel;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        stall_request;
    logic        result_ready;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    div_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .signed_div    (signed_div),
        .cancel        (cancel),
        .operand_1     (operand_1),
        .operand_2     (operand_2),
        .stall_request (stall_request),
        .result_ready  (result_ready),
        .result        (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Truncating division on magnitudes, then signs: quotient sign = xor, remainder follows dividend.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint unsigned ua, ub, q, r;
        bit na, nb;
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        na = sgn && a[31];
        nb = sgn && b[31];
        ua = na ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        ub = nb ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q  = ua / ub;
        r  = ua % ub;
        if (na ^ nb) q = 64'd0 - q;
        if (na)      r = 64'd0 - r;
        qq = q[31:0];
        rr = r[31:0];
        return {rr, qq};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input bit scramble, input string tag);
        logic [63:0] exp;
        int explat, lat, stalls;
        exp    = model(a, b, sgn);
        explat = (b == 32'd0) ? 2 : 33;
        lat    = -1;
        stalls = 0;
        @(negedge clk);
        start = 1'b1; operand_1 = a; operand_2 = b; signed_div = sgn;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (result_ready) begin
                lat = c;
                break;
            end
            if (stall_request) stalls++;
            @(negedge clk);
            if (scramble) begin
                operand_1 = $urandom;
                operand_2 = $urandom;
                signed_div = 1'($urandom);
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(explat));
        chk({tag, "_stalls"}, 64'(stalls), 64'(explat));
        chk({tag, "_res"}, result, exp);
        chk({tag, "_end_stall"}, 64'(stall_request), 64'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_drop"}, 64'(result_ready), 64'd0);
    endtask

    initial begin
        int saw_ready;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; cancel = 1'b0;
        operand_1 = '0; operand_2 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 64'(result_ready), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_stall", 64'(stall_request), 64'd0);
        rst = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 1'b0, "u100_7");
        run_div(-32'sd7, 32'd2, 1'b1, 1'b0, "s-7_2");
        run_div(32'd7, -32'sd2, 1'b1, 1'b0, "s7_-2");
        run_div(32'd5, 32'd0, 1'b1, 1'b0, "dz");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "ovf");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "umax");
        run_div(32'd1000, 32'd33, 1'b0, 1'b1, "scram");

        // Cancel at cycle 10, then a fresh divide at cycle 12.
        @(negedge clk);
        start = 1'b1; operand_1 = 32'd100; operand_2 = 32'd7; signed_div = 1'b0;
        saw_ready = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (result_ready) saw_ready = 1;
        end
        cancel = 1'b1;
        #1;
        chk("cancel_stall", 64'(stall_request), 64'd0);
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        #1;
        if (result_ready) saw_ready = 1;
        chk("cancel_noready", 64'(saw_ready), 64'd0);
        run_div(32'd9, 32'd3, 1'b0, 1'b0, "after_cancel");

        // Async reset in mid-operation.
        @(negedge clk);
        start = 1'b1; operand_1 = 32'd12345; operand_2 = 32'd17; signed_div = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_mid_ready", 64'(result_ready), 64'd0);
        chk("arst_mid_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Async reset while a result is being presented.
        @(negedge clk);
        start = 1'b1; operand_1 = 32'd100; operand_2 = 32'd7; signed_div = 1'b0;
        saw_ready = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (result_ready) begin
                saw_ready = 1;
                break;
            end
        end
        chk("arst_end_pre", result, model(32'd100, 32'd7, 1'b0));
        chk("arst_end_seen", 64'(saw_ready), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_end_ready", 64'(result_ready), 64'd0);
        chk("arst_end_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_div(32'd50, 32'd6, 1'b0, 1'b0, "post_rst");

        // Random operands, signedness, occasional zero/small divisors, scrambled inputs.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            int sel;
            a = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 32'd0;
            else if (sel < 4)  b = $urandom_range(1, 15);
            else if (sel == 4) b = 32'hFFFF_FFFF;
            else               b = $urandom;
            run_div(a, b, 1'($urandom), 1'b1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle iterative divider controller for the EX stage's DIV/DIVU path.
- Latches operands on a start request and runs a 32-iteration restoring shift-subtract sequence, applying sign fix-up for signed division.
- Raises a stall request for the pipeline and presents {remainder, quotient} for the HI/LO write.
- Handles cancel (pipeline flush) and divide-by-zero.

Parameters:
- WIDTH, 32: operand width; the result is 2*WIDTH.
- ITER_W, 6: counter width; must satisfy 2^ITER_W > WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  divide request from EX decode (funct is DIV or DIVU); held high until result_ready is seen.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- cancel  in  1  flush; aborts any operation.
- operand_1  in  WIDTH  dividend.
- operand_2  in  WIDTH  divisor.
- stall_request  out  1  hold the pipeline; combinational.
- result_ready  out  1  result valid, registered.
- result  out  2*WIDTH  [2W-1:W] = remainder (HI), [W-1:0] = quotient (LO).

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, result=0, result_ready=0, latched operands=0. Asserting rst mid-operation aborts immediately; no partial result survives.
- States: IDLE, DIV_ZERO, ON, END.
- IDLE:
  - start=1, cancel=0, operand_2==0 -> DIV_ZERO.
  - start=1, cancel=0, operand_2!=0 -> ON. On this transition:
    - latch |operand_1| and |operand_2| (two's-complement negate of negative values only when signed_div=1);
    - latch sign_q = op1[W-1]^op2[W-1] and sign_r = op1[W-1] (both forced to 0 when unsigned);
    - load the partial-remainder/dividend register {W'b0, |op1|}; counter=0.
  - Otherwise stay in IDLE.
- ON: one restoring step per cycle:
  - shift the working register left 1;
  - trial-subtract the divisor from the upper half;
  - if non-negative, keep the difference and set the quotient LSB to 1, else 0;
  - counter increments each step.
  - After the step with counter==WIDTH-1, go to END and register result with the fix-up: quotient negated if sign_q, remainder negated if sign_r.
- DIV_ZERO: one cycle, result=0, then -> END.
- END: result_ready=1 and result held stable. When start=0, go to IDLE and drop result_ready. While start stays 1, remain in END.
- cancel=1 in any state: next state IDLE, result_ready=0, result=0. cancel overrides start in the same cycle.
- start dropping to 0 in ON or DIV_ZERO is treated as cancel.
- stall_request = start & ~cancel & (state != END). It is low in the END cycle so EX advances and captures the result.
- Latency: start sampled in cycle 0 -> ON in cycles 1..32 -> result_ready in cycle 33. Divide-by-zero: result_ready in cycle 2.
- Operand changes after the IDLE->ON transition are ignored.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient=0x80000000, remainder=0. No trap.
- Back-to-back divides: a new start is accepted only after one IDLE cycle, i.e. after start has dropped.

Decomposition:
- Shared package / define file holds:
  - state encodings DIV_IDLE, DIV_ZERO, DIV_ON, DIV_END (2 bits);
  - WIDTH default;
  - the DIV_ITER=32 constant.
- One combinational sub-module, div_step:
  - inputs: working register and divisor;
  - outputs: the next working register after shift, trial-subtract and quotient-bit insert.
- div_sequencer owns the FSM, counter, sign latch and fix-up.

Test Plan:
- Unsigned: start=1, DIVU, 100 / 7 -> stall_request high for cycles 0..32, result_ready at cycle 33, result={32'd2, 32'd14}. Drop start -> IDLE next cycle.
- Signed: DIV, -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV, 7 / -2 -> quotient -3, remainder 1.
- Divide by zero: DIV, 5 / 0 -> result_ready at cycle 2, result=64'h0, stall released in END.
- Cancel mid-operation:
  - cancel=1 at cycle 10 -> IDLE at cycle 11, result_ready never asserts, stall_request low from cycle 10.
  - A new start at cycle 12 with 9 / 3 -> {0, 3} at cycle 45.
- Async reset: assert rst at cycle 20 between clock edges -> result_ready=0 and result=0 immediately; after release, state IDLE.
- Edge values:
  - signed 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000};
  - unsigned 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF};
  - operand changes during ON leave the result unaffected.
